fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_if.sv | 22 ++
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - Memory-request and decoder-handshake bundle for fetch_ctrl
interface fetch_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        pred_taken;

  modport master (
    output mem_req, mem_addr, dec_valid, dec_inst, dec_pc, pred_taken,
    input  mem_valid, mem_data, dec_ready
  );

  modport slave (
    input  mem_req, mem_addr, dec_valid, dec_inst, dec_pc, pred_taken,
    output mem_valid, mem_data, dec_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - Instruction fetch controller: one-in-flight word fetch into an in-order queue.
// Optional FETCH_JAL_PREDICT_EN: follow JAL targets at fetch time and tag the entry as predicted-taken.
module fetch_ctrl #(
  parameter int          IQ_DEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rdy_in,
  input  logic         clear,
  input  logic [31:0]  clear_pc,
  fetch_ctrl_if.master bus
);
  localparam int                    DEPTH = 1 << IQ_DEPTH_LOG;
  localparam logic [IQ_DEPTH_LOG:0] FULL  = (IQ_DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                  state, state_nxt;
  logic [31:0]             fetch_pc, fetch_pc_nxt;
  logic [31:0]             mem_addr_q, mem_addr_nxt;
  logic                    mem_req_q, mem_req_nxt;
  logic [IQ_DEPTH_LOG:0]   count, count_nxt;
  logic [IQ_DEPTH_LOG-1:0] head, head_nxt, tail, tail_nxt;
  logic                    push, pop;
  logic [31:0]             next_pc;

  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];

`ifdef FETCH_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] jal_off;
  logic        pred_q [DEPTH];

  assign is_jal  = (bus.mem_data[6:0] == 7'b1101111);
  assign jal_off = {{11{bus.mem_data[31]}}, bus.mem_data[31], bus.mem_data[19:12],
                    bus.mem_data[20], bus.mem_data[30:21], 1'b0};
  assign next_pc = is_jal ? fetch_pc + jal_off : fetch_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (push) pred_q[tail] <= is_jal;
  end

  // Gated by occupancy so the unreset pred storage never leaks out while empty.
  assign bus.pred_taken = (count != '0) && pred_q[head];
`else
  assign next_pc        = fetch_pc + 32'd4;
  assign bus.pred_taken = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      mem_addr_q <= mem_addr_nxt;
      mem_req_q  <= mem_req_nxt;
      count      <= count_nxt;
      head       <= head_nxt;
      tail       <= tail_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[tail] <= bus.mem_data;
      pc_q[tail]   <= fetch_pc;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    mem_addr_nxt = mem_addr_q;
    mem_req_nxt  = mem_req_q;
    count_nxt    = count;
    head_nxt     = head;
    tail_nxt     = tail;
    push         = 1'b0;
    pop          = 1'b0;

    if (rdy_in) begin
      mem_req_nxt = 1'b0;
      if (clear) begin
        count_nxt    = '0;
        head_nxt     = '0;
        tail_nxt     = '0;
        fetch_pc_nxt = clear_pc;
        // A response landing in the clear cycle is the one being dropped, so nothing stays pending.
        case (state)
          WAIT, DROP: state_nxt = bus.mem_valid ? IDLE : DROP;
          default:    state_nxt = IDLE;
        endcase
      end else begin
        pop = bus.dec_valid && bus.dec_ready;
        case (state)
          IDLE: begin
            if (count < FULL) begin
              mem_req_nxt  = 1'b1;
              mem_addr_nxt = fetch_pc;
              state_nxt    = WAIT;
            end
          end
          WAIT: begin
            if (bus.mem_valid) begin
              push         = 1'b1;
              fetch_pc_nxt = next_pc;
              state_nxt    = IDLE;
            end
          end
          DROP: begin
            if (bus.mem_valid) state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
        if (pop)  head_nxt = head + IQ_DEPTH_LOG'(1);
        if (push) tail_nxt = tail + IQ_DEPTH_LOG'(1);
        count_nxt = count + (IQ_DEPTH_LOG + 1)'(push) - (IQ_DEPTH_LOG + 1)'(pop);
      end
    end
  end

  // The request register survives a pause so a pulse blocked by rdy_in is still seen afterwards.
  assign bus.mem_req   = mem_req_q && rdy_in;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.dec_valid = (count != '0);
  assign bus.dec_inst  = inst_q[head];
  assign bus.dec_pc    = pc_q[head];
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - Self-checking bench for fetch_ctrl against a queue-level fetch model.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        rdy_in;
  logic        clear;
  logic [31:0] clear_pc;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.IQ_DEPTH_LOG(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .rdy_in(rdy_in), .clear(clear), .clear_pc(clear_pc), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } ent_t;

  int          total = 0;
  int          bad = 0;
  ent_t        mq[$];
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] req_log[$];
  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  int          pend, pend_epoch, resp_epoch, epoch, lat;
  int          addr_bad, overlap;

`ifdef FETCH_JAL_PREDICT_EN
  localparam logic [31:0] JAL_NEXT = 32'h18;
  localparam logic        JAL_PRED = 1'b1;
`else
  localparam logic [31:0] JAL_NEXT = 32'hC;
  localparam logic        JAL_PRED = 1'b0;
`endif

  function automatic logic pred_of(input logic [31:0] inst);
`ifdef FETCH_JAL_PREDICT_EN
    return inst[6:0] == 7'h6F;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst);
`ifdef FETCH_JAL_PREDICT_EN
    int imm;
    if (inst[6:0] == 7'h6F) begin
      imm = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
            - (inst[31] ? 1048576 : 0);
      return pc + 32'(imm);
    end
`endif
    return pc + 32'd4;
  endfunction

  task automatic fetch_word(input logic [31:0] a, output logic [31:0] w);
    if (!mem_img.exists(a)) begin
      w = $urandom;
      if (w[6:0] == 7'h6F) w[0] = 1'b0;
      if ($urandom_range(0, 7) == 0) w[6:0] = 7'h6F;
      mem_img[a] = w;
    end
    w = mem_img[a];
  endtask

  // Plays the memory for the current cycle, advances the model across the next edge, ends at the next negedge.
  task automatic advance();
    logic [31:0] w;
    ent_t        e;
    bus.mem_valid = 1'b0;
    if (rdy_in && pend > 0) begin
      pend--;
      if (pend == 0) begin
        fetch_word(pend_addr, w);
        bus.mem_valid = 1'b1;
        bus.mem_data  = w;
        resp_epoch    = pend_epoch;
      end
    end
    if (bus.mem_req) begin
      if (pend > 0 || bus.mem_valid) overlap++;
      if (bus.mem_addr !== exp_pc) addr_bad++;
      req_log.push_back(bus.mem_addr);
      pend       = lat;
      pend_addr  = bus.mem_addr;
      pend_epoch = epoch;
    end
    if (rdy_in) begin
      if (clear) begin
        mq.delete();
        exp_pc = clear_pc;
        epoch++;
      end else begin
        if (bus.dec_ready && mq.size() > 0) void'(mq.pop_front());
        if (bus.mem_valid && resp_epoch == epoch) begin
          e.pc   = exp_pc;
          e.inst = bus.mem_data;
          e.pred = pred_of(bus.mem_data);
          mq.push_back(e);
          exp_pc = model_next(exp_pc, bus.mem_data);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; rdy_in = 1'b1; clear = 1'b0; clear_pc = '0;
    bus.dec_ready = 1'b0; bus.mem_valid = 1'b0; bus.mem_data = '0;
    lat = 1; pend = 0; epoch = 0; exp_pc = 32'h0; addr_bad = 0; overlap = 0;
    for (int i = 0; i < 16; i++) mem_img[32'(i * 4)] = ($urandom & ~32'h7F) | 32'h13;
    repeat (2) @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", bus.mem_req); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", bus.mem_addr); end
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid got=%b want=0", bus.dec_valid); end
    total++; if (bus.pred_taken !== 1'b0) begin bad++; $display("FAIL rst_pred got=%b want=0", bus.pred_taken); end
    reset = 1'b1;
    repeat (4) advance();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin
      bad++; $display("FAIL pre_async_req got=%b/%h want=1/4", bus.mem_req, bus.mem_addr);
    end
    #1 reset = 1'b0;
    #1;
    total++; if ({bus.mem_req, bus.dec_valid, bus.mem_addr} !== {2'b00, 32'h0}) begin
      bad++; $display("FAIL async_reset got=%b%b/%h want=00/0", bus.mem_req, bus.dec_valid, bus.mem_addr);
    end
    mq.delete(); req_log.delete(); exp_pc = 32'h0; pend = 0; epoch++;
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [31:0] pops[$];
    logic [31:0] got;
    int n = 0;
    reset = 1'b1; bus.dec_ready = 1'b1; lat = 1;
    while (pops.size() < 3 && n < 40) begin
      if (bus.dec_valid) begin
        total++;
        if (mq.size() == 0) begin bad++; $display("FAIL stream_extra got=%h want=none", bus.dec_pc); end
        else if (bus.dec_pc !== mq[0].pc || bus.dec_inst !== mq[0].inst) begin
          bad++; $display("FAIL stream_head got=%h/%h want=%h/%h", bus.dec_pc, bus.dec_inst, mq[0].pc, mq[0].inst);
        end
        pops.push_back(bus.dec_pc);
      end
      advance(); n++;
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < pops.size()) ? pops[i] : 32'hDEAD_BEEF;
      total++; if (got !== 32'(i * 4)) begin bad++; $display("FAIL stream_dec_pc%0d got=%h want=%h", i, got, 32'(i * 4)); end
      got = (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
      total++; if (got !== 32'(i * 4)) begin bad++; $display("FAIL stream_addr%0d got=%h want=%h", i, got, 32'(i * 4)); end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) mem_img[32'h40 + 32'(i * 4)] = 32'h0000_0013;
    clear = 1'b1; clear_pc = 32'h40; advance(); clear = 1'b0;
    bus.dec_ready = 1'b0; req_log.delete();
    repeat (30) advance();
    total++; if (req_log.size() != 4) begin bad++; $display("FAIL full_req_count got=%0d want=4", req_log.size()); end
    total++; if ({bus.dec_valid, bus.dec_pc, bus.dec_inst} !== {1'b1, 32'h40, 32'h13}) begin
      bad++; $display("FAIL full_head got=%b/%h/%h want=1/40/13", bus.dec_valid, bus.dec_pc, bus.dec_inst);
    end
    bus.dec_ready = 1'b1; advance(); bus.dec_ready = 1'b0;
    req_log.delete();
    repeat (10) advance();
    total++; if (req_log.size() != 1) begin bad++; $display("FAIL refill_count got=%0d want=1", req_log.size()); end
    else begin
      total++; if (req_log[0] !== 32'h50) begin bad++; $display("FAIL refill_addr got=%h want=50", req_log[0]); end
    end
    total++; if (bus.dec_pc !== 32'h44) begin bad++; $display("FAIL refill_head got=%h want=44", bus.dec_pc); end
  endtask

  task automatic test_clear_wait();
    int n = 0;
    int seen = 0;
    bus.dec_ready = 1'b1; lat = 3;
    while (!bus.mem_req && n < 20) begin advance(); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL clrw_no_req got=%0d want<20", n); end
    advance();
    clear = 1'b1; clear_pc = 32'h100; advance(); clear = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      if (bus.dec_valid) seen++;
      advance(); n++;
    end
    total++; if (n >= 20) begin bad++; $display("FAIL clrw_timeout got=%0d want<20", n); end
    total++; if (seen != 0) begin bad++; $display("FAIL clrw_stale_enq got=%0d want=0", seen); end
    total++; if (bus.mem_addr !== 32'h100) begin bad++; $display("FAIL clrw_addr got=%h want=100", bus.mem_addr); end
    n = 0;
    while (!bus.dec_valid && n < 20) begin advance(); n++; end
    total++; if (bus.dec_pc !== 32'h100 || !bus.dec_valid) begin
      bad++; $display("FAIL clrw_head got=%b/%h want=1/100", bus.dec_valid, bus.dec_pc);
    end
  endtask

  task automatic test_clear_same();
    int n = 0;
    bus.dec_ready = 1'b1; lat = 2;
    while (!bus.mem_req && n < 20) begin advance(); n++; end
    advance();
    advance();
    clear = 1'b1; clear_pc = 32'h200; advance(); clear = 1'b0;
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL clrs_valid got=%b want=0", bus.dec_valid); end
    n = 0;
    while (!bus.mem_req && n < 10) begin advance(); n++; end
    total++; if (n != 1) begin bad++; $display("FAIL clrs_reissue_lat got=%0d want=1", n); end
    total++; if (bus.mem_addr !== 32'h200) begin bad++; $display("FAIL clrs_addr got=%h want=200", bus.mem_addr); end
  endtask

  task automatic test_pause();
    logic [96:0] snap;
    bus.dec_ready = 1'b1; lat = 1;
    repeat (7) advance();
    snap = {bus.dec_valid, bus.dec_pc, bus.dec_inst, bus.mem_addr};
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.mem_req !== 1'b0 || {bus.dec_valid, bus.dec_pc, bus.dec_inst, bus.mem_addr} !== snap) begin
        bad++; $display("FAIL pause_hold%0d got=%b/%h want=0/%h", i, bus.mem_req,
                        {bus.dec_valid, bus.dec_pc, bus.dec_inst, bus.mem_addr}, snap);
      end
      advance();
    end
    rdy_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (bus.dec_valid !== (mq.size() != 0)) begin
        bad++; $display("FAIL resume_valid%0d got=%b want=%b", i, bus.dec_valid, mq.size() != 0);
      end else if (bus.dec_valid && (bus.dec_pc !== mq[0].pc || bus.dec_inst !== mq[0].inst)) begin
        bad++; $display("FAIL resume_head%0d got=%h/%h want=%h/%h", i, bus.dec_pc, bus.dec_inst, mq[0].pc, mq[0].inst);
      end
      advance();
    end
  endtask

  task automatic test_jal();
    int   n = 0;
    logic seen8 = 1'b0;
    logic pt = 1'bx;
    logic [31:0] got;
    mem_img[32'h0] = 32'h13; mem_img[32'h4] = 32'h13; mem_img[32'h8] = 32'h0100_006F;
    mem_img[32'hC] = 32'h33; mem_img[32'h18] = 32'h13;
    bus.dec_ready = 1'b1; lat = 1;
    clear = 1'b1; clear_pc = 32'h0; advance(); clear = 1'b0;
    req_log.delete();
    while ((req_log.size() < 4 || !seen8) && n < 60) begin
      if (bus.dec_valid && bus.dec_pc == 32'h8 && !seen8) begin seen8 = 1'b1; pt = bus.pred_taken; end
      advance(); n++;
    end
    total++; if (n >= 60) begin bad++; $display("FAIL jal_timeout got=%0d want<60", n); end
    got = (req_log.size() > 3) ? req_log[3] : 32'hDEAD_BEEF;
    total++; if (got !== JAL_NEXT) begin bad++; $display("FAIL jal_next_addr got=%h want=%h", got, JAL_NEXT); end
    total++; if (pt !== JAL_PRED) begin bad++; $display("FAIL jal_pred got=%b want=%b", pt, JAL_PRED); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.dec_ready = ($urandom_range(0, 3) != 0);
      rdy_in        = ($urandom_range(0, 15) != 0);
      clear         = ($urandom_range(0, 39) == 0);
      clear_pc      = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      lat           = $urandom_range(1, 3);
      total++;
      if (bus.dec_valid !== (mq.size() != 0)) begin
        bad++; $display("FAIL rnd_valid%0d got=%b want=%b", i, bus.dec_valid, mq.size() != 0);
      end else if (bus.dec_valid && (bus.dec_pc !== mq[0].pc || bus.dec_inst !== mq[0].inst
                                      || bus.pred_taken !== mq[0].pred)) begin
        bad++; $display("FAIL rnd_head%0d got=%h/%h/%b want=%h/%h/%b", i, bus.dec_pc, bus.dec_inst,
                        bus.pred_taken, mq[0].pc, mq[0].inst, mq[0].pred);
      end
      advance();
    end
    rdy_in = 1'b1; clear = 1'b0;
    total++; if (addr_bad != 0) begin bad++; $display("FAIL req_addr_seq got=%0d want=0", addr_bad); end
    total++; if (overlap != 0) begin bad++; $display("FAIL one_in_flight got=%0d want=0", overlap); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_clear_wait();
    test_clear_same();
    test_pause();
    test_jal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
